mem_dump_tx: RTL and testbench
==============================

# mem_dump_tx

Memory dump transmitter for the RISC-V core. On a start pulse it reads a range of word-indexed memory, such as instruction memory, through a synchronous read port. It streams each entry out over an 8N1 UART line as an address/word pair. It performs the inverse of the bench-side program load: the load writes "address word" pairs into memory, and this block reads memory back out as the same pairs, so images can be checked or captured off-chip.

## Interface
Parameters:
- CLKS_PER_BIT, default 16: clock cycles per UART bit; must be ≥ 2.
- ADDR_W, default 10: width of the word index into memory.

Ports:
- clk_  in  1  single clock; all logic is on the rising edge.
- rst_n  in  1  reset: asynchronous, active-low.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_idx  in  ADDR_W  first word index; sampled with start.
- count  in  ADDR_W+1  number of words to dump; sampled with start.
- mem_rd  out  1  read strobe, one cycle per word.
- mem_addr  out  ADDR_W  word index for the read; valid while mem_rd=1.
- mem_rdata  in  32  read data; valid the cycle after mem_rd.
- tx  out  1  UART serial output; idles high.
- busy  out  1  high from start acceptance until the dump completes.
- done  out  1  one-cycle pulse when the dump completes.

## Operation
- FSM states and transitions:
  - IDLE → READ on start with count≠0.
  - IDLE → DONE on start with count=0.
  - READ → LATCH → SEND.
  - SEND → READ after byte 7 if words remain.
  - SEND → DONE after byte 7 of the last word.
  - DONE → IDLE.
- READ: mem_rd=1 and mem_addr=current index for exactly one cycle.
- LATCH: a 64-bit frame register is loaded.
  - Upper half: {idx, 2'b00}, zero-extended to 32 bits. This is the byte address.
  - Lower half: mem_rdata.
- SEND: 8 bytes are transmitted most-significant byte first: address[31:24] … address[7:0], then word[31:24] … word[7:0].
- Each byte is sent as 8N1:
  - 1 start bit (0).
  - 8 data bits, LSB first.
  - 1 stop bit (1).
  - Each bit lasts CLKS_PER_BIT cycles.
- Bytes within a word are back-to-back with no idle gap.
- Index arithmetic: idx starts at base_idx and increments mod 2^ADDR_W, so it wraps from max to 0. The remaining count decrements once per word.
- count > 2^ADDR_W is legal. Addresses wrap and repeat.
- start is ignored while busy=1. base_idx and count are not re-sampled.

## Timing
- Reset values (asynchronous assert, immediate): tx=1, busy=0, done=0, mem_rd=0, mem_addr=0. FSM goes to IDLE and all counters clear.
- Reset mid-frame: the line returns high immediately. The truncated byte is not resumed after release.
- Start latency, with start sampled at edge E0:
  - busy=1 and mem_rd=1 from E0 to E1.
  - mem_rdata is captured at E2.
  - tx falls to the start bit at E2.
- Frame length: 80·CLKS_PER_BIT cycles per word.
- Inter-word gap: tx is held high for exactly 2 cycles (READ + LATCH). mem_rd for the next word is asserted at the edge that ends the previous stop bit.
- Word period: 80·CLKS_PER_BIT + 2 cycles.
- Completion: at the edge ending the final stop bit, busy falls and done=1 for one cycle. A start in that done cycle is ignored, and start is accepted from the next cycle.
- count=0: busy=1 for one cycle, then done pulses. No mem_rd and tx stays high.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- Reset: assert rst_n=0 mid-byte while transmitting → tx=1, busy=0, mem_rd=0 in the same cycle. After release, tx stays high until a new start.
- Single word: CLKS_PER_BIT=4, mem[5]=0xDEADBEEF, base_idx=5, count=1 → one mem_rd with mem_addr=5. Decoded bytes are 00 00 00 14 DE AD BE EF. busy stays high 2+320 cycles, then done pulses once.
- Multi-word with gap: base_idx=0, count=3, mem[0..2]=0x00000013, 0x00100093, 0x04500193 → three frames with addresses 0, 4, 8. tx is high exactly 2 cycles between frames, and mem_rd pulses exactly 3 times.
- Wrap-around: ADDR_W=4, base_idx=15, count=2 → mem_addr sequence is 15 then 0, and frame addresses are 0x0000003C then 0x00000000.
- count=0 and start while busy: start with count=0 → done pulses one cycle later and tx never leaves 1. During a 2-word dump, pulsing start with base_idx=9 → no extra mem_rd, and only 2 frames are sent.
- Bit timing: CLKS_PER_BIT=16, byte 0xA5 → each tx level is held exactly 16 cycles. The bit sequence is 0,1,0,1,0,0,1,0,1,1.

Source files
------------

// File: rtl/mem_dump_tx.sv
// Memory dump transmitter: reads a range of word-indexed memory and streams each
// entry over an 8N1 UART line as an 8-byte {byte address, word} frame, MSB first.
module mem_dump_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int ADDR_W       = 10
) (
  input  logic              clk_,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_idx,
  input  logic [ADDR_W:0]   count,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {IDLE, READ, LATCH, SEND, DONE} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] idx, idx_n;
  logic [ADDR_W:0]   remaining, remaining_n;
  logic [63:0]       frame, frame_n;
  logic [2:0]        byte_cnt, byte_cnt_n;
  logic [3:0]        bit_cnt, bit_cnt_n;
  logic [CW-1:0]     clk_cnt, clk_cnt_n;
  logic              tx_n, busy_n, done_n, mem_rd_n;
  logic [ADDR_W-1:0] mem_addr_n;
  logic [7:0]        cur_byte;

  // The byte on the wire is always the top of the frame; it shifts up per byte.
  assign cur_byte = frame[63:56];

  // NOTE: every signal driven here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_n     = state;
    idx_n       = idx;
    remaining_n = remaining;
    frame_n     = frame;
    byte_cnt_n  = byte_cnt;
    bit_cnt_n   = bit_cnt;
    clk_cnt_n   = clk_cnt;
    tx_n        = 1'b1;
    busy_n      = busy;
    done_n      = 1'b0;
    mem_rd_n    = 1'b0;
    mem_addr_n  = mem_addr;

    case (state)
      IDLE: begin
        if (start) begin
          busy_n      = 1'b1;
          idx_n       = base_idx;
          remaining_n = count;
          if (count != '0) begin
            state_n    = READ;
            mem_rd_n   = 1'b1;
            mem_addr_n = base_idx;
          end else begin
            state_n = DONE;
          end
        end
      end

      READ: state_n = LATCH;

      LATCH: begin
        state_n     = SEND;
        frame_n     = {32'({idx, 2'b00}), mem_rdata};
        idx_n       = idx + ADDR_W'(1);
        remaining_n = remaining - (ADDR_W + 1)'(1);
        byte_cnt_n  = '0;
        bit_cnt_n   = '0;
        clk_cnt_n   = '0;
        tx_n        = 1'b0;
      end

      SEND: begin
        tx_n = tx;
        if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
          clk_cnt_n = '0;
          if (bit_cnt == 4'd9) begin
            if (byte_cnt == 3'd7) begin
              tx_n = 1'b1;
              if (remaining != '0) begin
                state_n    = READ;
                mem_rd_n   = 1'b1;
                mem_addr_n = idx;
              end else begin
                state_n = DONE;
                busy_n  = 1'b0;
                done_n  = 1'b1;
              end
            end else begin
              byte_cnt_n = byte_cnt + 3'd1;
              frame_n    = {frame[55:0], 8'h00};
              bit_cnt_n  = '0;
              tx_n       = 1'b0;
            end
          end else begin
            // bit_cnt k is on the wire now; the next bit is data bit k or the stop bit.
            bit_cnt_n = bit_cnt + 4'd1;
            tx_n      = (bit_cnt == 4'd8) ? 1'b1 : cur_byte[bit_cnt[2:0]];
          end
        end else begin
          clk_cnt_n = clk_cnt + CW'(1);
        end
      end

      DONE: begin
        // Arriving from IDLE (count=0) done is still low: spend one more cycle to pulse it.
        if (!done) begin
          busy_n = 1'b0;
          done_n = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above.
  always_ff @(posedge clk_ or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      remaining <= '0;
      frame     <= '0;
      byte_cnt  <= '0;
      bit_cnt   <= '0;
      clk_cnt   <= '0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      remaining <= remaining_n;
      frame     <= frame_n;
      byte_cnt  <= byte_cnt_n;
      bit_cnt   <= bit_cnt_n;
      clk_cnt   <= clk_cnt_n;
      tx        <= tx_n;
      busy      <= busy_n;
      done      <= done_n;
      mem_rd    <= mem_rd_n;
      mem_addr  <= mem_addr_n;
    end
  end

endmodule

// File: tb/tb_mem_dump_tx.sv
// Self-checking bench for mem_dump_tx: per-cycle waveform model computed from the
// frame timing arithmetic, plus an independent UART decoder on the sampled line.
module tb_mem_dump_tx;

  localparam int C   = 4;
  localparam int AW  = 4;
  localparam int PER = 80 * C + 2;

  logic          clk_ = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_idx;
  logic [AW:0]   count;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata;
  logic          tx, busy, done;

  logic [31:0] mem [16];

  typedef struct {
    logic          tx;
    logic          busy;
    logic          done;
    logic          rd;
    logic [AW-1:0] addr;
  } samp_t;

  int n_total = 0;
  int n_bad   = 0;
  int run_id  = 0;

  mem_dump_tx #(.CLKS_PER_BIT(C), .ADDR_W(AW)) dut (
    .clk_      (clk_),
    .rst_n     (rst_n),
    .start     (start),
    .base_idx  (base_idx),
    .count     (count),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .tx        (tx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk_ = ~clk_;

  // Synchronous-read memory: data appears the cycle after the strobe.
  always @(posedge clk_) if (mem_rd) mem_rdata <= mem[mem_addr];

  task automatic check(input string tag, input longint obs, input longint exp);
    n_total++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int base, input int k, input int b);
    logic [63:0] f;
    int a;
    a = (base + k) % 16;
    f = {32'(a * 4), mem[a]};
    return 8'(f >> (56 - 8 * b));
  endfunction

  function automatic logic exp_tx(input int t, input int base, input int cnt);
    int k, o, b, j;
    logic [7:0] v;
    if (cnt == 0) return 1'b1;
    k = t / PER;
    o = t - k * PER - 2;
    if (k >= cnt || o < 0 || o >= 80 * C) return 1'b1;
    b = o / (10 * C);
    j = (o % (10 * C)) / C;
    if (j == 0) return 1'b0;
    if (j == 9) return 1'b1;
    v = exp_byte(base, k, b);
    return v[j - 1];
  endfunction

  // Start a dump and compare every sampled cycle against the model. A second start
  // is pulsed at cycle inj (with base_idx=9) and another in the done cycle.
  task automatic run_dump(input int base, input int cnt, input int inj);
    samp_t s[$];
    logic [7:0] got[$];
    int e_end, n, k;
    int e_tx, e_busy, e_done, e_rd, e_addr, n_rd, t;
    logic [7:0] v;
    logic ok;
    run_id++;
    e_end = (cnt == 0) ? 1 : cnt * PER;
    n     = e_end + 4;
    @(negedge clk_);
    base_idx = AW'(base);
    count    = (AW + 1)'(cnt);
    start    = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_);
      s.push_back('{tx, busy, done, mem_rd, mem_addr});
      start = (i == inj) || (i == e_end);
      if (start) base_idx = AW'(9);
    end
    start = 1'b0;

    e_tx = 0; e_busy = 0; e_done = 0; e_rd = 0; e_addr = 0; n_rd = 0;
    for (int i = 0; i < n; i++) begin
      logic x_busy, x_rd;
      x_busy = (cnt == 0) ? (i == 0) : (i < e_end);
      x_rd   = (cnt > 0) && (i % PER == 0) && (i / PER < cnt);
      if (s[i].tx !== exp_tx(i, base, cnt)) e_tx++;
      if (s[i].busy !== x_busy) e_busy++;
      if (s[i].done !== (i == e_end)) e_done++;
      if (s[i].rd !== x_rd) e_rd++;
      if (x_rd && s[i].addr !== AW'((base + i / PER) % 16)) e_addr++;
      if (s[i].rd === 1'b1) n_rd++;
    end
    check($sformatf("r%0d_tx_wave_errs", run_id), e_tx, 0);
    check($sformatf("r%0d_busy_errs", run_id), e_busy, 0);
    check($sformatf("r%0d_done_errs", run_id), e_done, 0);
    check($sformatf("r%0d_rd_errs", run_id), e_rd, 0);
    check($sformatf("r%0d_addr_errs", run_id), e_addr, 0);
    check($sformatf("r%0d_rd_pulses", run_id), n_rd, cnt);

    // Independent 8N1 decode at bit mid-points.
    t = 0;
    while (t < n) begin
      if (s[t].tx === 1'b0 && t + 10 * C <= n) begin
        ok = (s[t + C / 2].tx === 1'b0) && (s[t + 9 * C + C / 2].tx === 1'b1);
        for (int j = 0; j < 8; j++) v[j] = s[t + (j + 1) * C + C / 2].tx;
        check($sformatf("r%0d_framing", run_id), ok, 1);
        got.push_back(v);
        t += 9 * C + C / 2 + 1;
      end else begin
        t++;
      end
    end
    check($sformatf("r%0d_nbytes", run_id), got.size(), 8 * cnt);
    k = 0;
    foreach (got[i]) begin
      if (i < 8 * cnt)
        check($sformatf("r%0d_byte%0d", run_id, i), got[i], exp_byte(base, i / 8, i % 8));
    end
  endtask

  initial begin
    int w, cnt0, base0;
    rst_n    = 1'b0;
    start    = 1'b0;
    base_idx = '0;
    count    = '0;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    #23;
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_mem_rd", mem_rd, 0);
    check("reset_mem_addr", mem_addr, 0);
    @(negedge clk_);
    rst_n = 1'b1;

    mem[5] = 32'hDEADBEEF;
    run_dump(5, 1, -1);
    mem[0] = 32'h00000013;
    mem[1] = 32'h00100093;
    mem[2] = 32'h04500193;
    run_dump(0, 3, -1);
    run_dump(15, 2, -1);
    run_dump(0, 0, -1);
    run_dump(3, 2, 57);
    run_dump(11, 18, -1);
    for (int r = 0; r < 3; r++) begin
      base0 = $urandom_range(0, 15);
      cnt0  = $urandom_range(1, 4);
      for (int i = 0; i < 16; i++) mem[i] = $urandom;
      run_dump(base0, cnt0, $urandom_range(1, 300));
    end

    // Reset in the middle of a byte.
    @(negedge clk_);
    base_idx = AW'(2);
    count    = (AW + 1)'(1);
    start    = 1'b1;
    @(negedge clk_);
    start = 1'b0;
    w = 0;
    while (tx !== 1'b0 && w < 50) begin
      @(negedge clk_);
      w++;
    end
    check("rst_mid_reached_start_bit", w < 50, 1);
    repeat (C + 1) @(negedge clk_);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_tx", tx, 1);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_mem_rd", mem_rd, 0);
    check("rst_mid_done", done, 0);
    @(negedge clk_);
    rst_n = 1'b1;
    w = 0;
    for (int i = 0; i < 12 * C; i++) begin
      @(negedge clk_);
      if (tx !== 1'b1 || busy !== 1'b0 || mem_rd !== 1'b0) w++;
    end
    check("rst_mid_quiet_after_release", w, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
